chip_spreader: RTL and testbench

Direct-sequence spreading stage of the 802.15.4 (Zigbee) O-QPSK transmit path. Accepts 4-bit data symbols through a valid/ready handshake and maps each one to its 32-chip PN sequence. Emits the chips serially, MSB (chip c0) first, at a programmable chip rate. It sits directly downstream of the symbol selection muxes and feeds the I/Q chip splitter and pulse shaper.

---
 rtl/chip_spreader.sv | 120 ++++++++++++
 tb/tb_chip_spreader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip_spreader.sv
`default_nettype none
// ------------------------------------------------------------------------
// chip_spreader : 802.15.4 O-QPSK symbol-to-32-chip PN spreader, rev 1.0
// ------------------------------------------------------------------------
module chip_spreader #(
  parameter int CHIP_DIV = 1
) (
  input  logic       inClk,
  input  logic       inRst,
  input  logic [3:0] inSymbol,
  input  logic       inSymValid,
  output logic       outSymReady,
  output logic       outChip,
  output logic       outChipValid,
  output logic [4:0] outChipIdx,
  output logic       outSymDone
);

  localparam int                DIV_W    = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CHIP_DIV - 1);
  localparam logic [31:0]       PN_BASE  = 32'hD9C3522E;
  localparam logic [31:0]       ODD_MASK = 32'h55555555;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SPREAD = 1'b1
  } state_t;

  function automatic logic [31:0] pn_seq(input logic [3:0] s);
    logic [63:0] dbl;
    logic [31:0] rot;
    dbl = {PN_BASE, PN_BASE} >> {s[2:0], 2'b00};
    rot = dbl[31:0];
    return s[3] ? (rot ^ ODD_MASK) : rot;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             empty_q, empty_d;
  logic [31:0]      shift_q, shift_d;
  logic [4:0]       idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d;
  logic             load;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    empty_d = empty_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    load    = 1'b0;

    // Accept and load are mutually exclusive: one needs empty, the other full.
    if (inSymValid && empty_q) begin
      hold_d  = inSymbol;
      empty_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!empty_q) load = 1'b1;
      end
      ST_SPREAD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shift_d = {shift_q[30:0], 1'b0};
          if (idx_q == 5'd31) begin
            if (!empty_q) load = 1'b1;
            else          state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d = pn_seq(hold_q);
      idx_d   = 5'd0;
      div_d   = '0;
      empty_d = 1'b1;
      state_d = ST_SPREAD;
    end

    done_d = (state_d == ST_SPREAD) && (idx_d == 5'd31) && (div_d == DIV_LAST);
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q <= ST_IDLE;
      hold_q  <= 4'd0;
      empty_q <= 1'b1;
      shift_q <= 32'd0;
      idx_q   <= 5'd0;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      empty_q <= empty_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign outSymReady  = empty_q;
  assign outChip      = shift_q[31];
  assign outChipValid = (state_q == ST_SPREAD);
  assign outChipIdx   = idx_q;
  assign outSymDone   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_chip_spreader.sv
`default_nettype none
// Testbench for chip_spreader: table-driven symbols plus multi-cycle corner
// sequences, with per-cycle chip expectations held in a scoreboard queue.
module tb_chip_spreader;

  typedef struct packed {
    logic       chip;
    logic [4:0] idx;
    logic       done;
  } exp_t;

  typedef struct {
    logic [3:0]  sym;
    logic [31:0] seq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sym1 = 4'd0, sym4 = 4'd0;
  logic       val1 = 1'b0, val4 = 1'b0;
  logic       rdy1, ch1, v1, dn1;
  logic       rdy4, ch4, v4, dn4;
  logic [4:0] idx1, idx4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run1 = 0, max1 = 0, run4 = 0, max4 = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int   done_cyc[$];
  vec_t tbl[6];

  chip_spreader #(.CHIP_DIV(1)) u_dut1 (
    .inClk(clk), .inRst(rst), .inSymbol(sym1), .inSymValid(val1),
    .outSymReady(rdy1), .outChip(ch1), .outChipValid(v1),
    .outChipIdx(idx1), .outSymDone(dn1)
  );

  chip_spreader #(.CHIP_DIV(4)) u_dut4 (
    .inClk(clk), .inRst(rst), .inSymbol(sym4), .inSymValid(val4),
    .outSymReady(rdy4), .outChip(ch4), .outChipValid(v4),
    .outChipIdx(idx4), .outSymDone(dn4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int which, input logic [31:0] seq);
    exp_t e;
    int   div;
    div = (which == 0) ? 1 : 4;
    for (int i = 0; i < 32; i++) begin
      for (int d = 0; d < div; d++) begin
        e.chip = seq[31-i];
        e.idx  = 5'(i);
        e.done = (i == 31) && (d == div - 1);
        if (which == 0) q1.push_back(e);
        else            q4.push_back(e);
      end
    end
  endtask

  task automatic accept_sym(input int which, input logic [3:0] s, input logic [31:0] seq,
                            output int edge_no);
    bit got;
    got = 1'b0;
    edge_no = -1;
    if (which == 0) begin sym1 = s; val1 = 1'b1; end
    else            begin sym4 = s; val4 = 1'b1; end
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk);
      if ((which == 0) ? rdy1 : rdy4) begin
        got = 1'b1;
        edge_no = cyc;
        push_exp(which, seq);
      end
    end
    #1;
    if (which == 0) val1 = 1'b0; else val4 = 1'b0;
    chk("accept_timeout", 32'(got), 32'd1);
    if (got) chk("ready_falls", (which == 0) ? rdy1 : rdy4, 32'd0);
  endtask

  task automatic wait_idle(input int which);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 1000 && !idle; n++) begin
      @(negedge clk);
      if (which == 0) idle = (q1.size() == 0) && !v1;
      else            idle = (q4.size() == 0) && !v4;
    end
    chk("idle_timeout", 32'(idle), 32'd1);
    chk("ready_back", (which == 0) ? rdy1 : rdy4, 32'd1);
  endtask

  always @(negedge clk) begin
    if (v1) begin
      run1++;
      if (run1 > max1) max1 = run1;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_extra_chip actual=valid required=idle idx=%0d", idx1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_chip", ch1, e1.chip);
        chk("dut1_idx", idx1, e1.idx);
        chk("dut1_done", dn1, e1.done);
      end
      if (dn1) done_cyc.push_back(cyc);
    end else begin
      run1 = 0;
      if (dn1) chk("dut1_done_idle", dn1, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (v4) begin
      run4++;
      if (run4 > max4) max4 = run4;
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_extra_chip actual=valid required=idle idx=%0d", idx4);
      end else begin
        e4 = q4.pop_front();
        chk("dut4_chip", ch4, e4.chip);
        chk("dut4_idx", idx4, e4.idx);
        chk("dut4_done", dn4, e4.done);
      end
    end else begin
      run4 = 0;
      if (dn4) chk("dut4_done_idle", dn4, 32'd0);
    end
  end

  initial begin
    int  ea, eb;
    bit  hit;

    tbl[0] = '{4'd0,  32'hD9C3522E};
    tbl[1] = '{4'd1,  32'hED9C3522};
    tbl[2] = '{4'd8,  32'h8C96077B};
    tbl[3] = '{4'd15, 32'hC96077B8};
    tbl[4] = '{4'd3,  32'h22ED9C35};
    tbl[5] = '{4'd12, 32'h077B8C96};

    #1 rst = 1'b1;
    #1;
    chk("rst_chip", ch1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_idx", idx1, 0);
    chk("rst_done", dn1, 0);
    chk("rst_ready", rdy1, 1);
    chk("rst_ready4", rdy4, 1);
    @(negedge clk);
    #1 rst = 1'b0;

    // Single symbols, one at a time
    for (int i = 0; i < 6; i++) begin
      accept_sym(0, tbl[i].sym, tbl[i].seq, ea);
      wait_idle(0);
    end

    // Back-to-back symbols 3 then 12: gapless 64-chip stream
    max1 = 0;
    done_cyc.delete();
    accept_sym(0, 4'd3, 32'h22ED9C35, ea);
    accept_sym(0, 4'd12, 32'h077B8C96, eb);
    chk("b2b_accept_gap", 32'(eb - ea), 32'd2);
    wait_idle(0);
    chk("b2b_valid_run", max1, 64);
    chk("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) chk("b2b_done_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd32);

    // CHIP_DIV=4 instance
    max4 = 0;
    accept_sym(1, 4'd0, 32'hD9C3522E, ea);
    wait_idle(1);
    chk("div4_valid_run", max4, 128);

    // Asynchronous reset in the middle of chip 10
    accept_sym(0, 4'd0, 32'hD9C3522E, ea);
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      hit = v1 && (idx1 == 5'd10);
    end
    chk("reach_idx10", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_chip", ch1, 0);
    chk("arst_valid", v1, 0);
    chk("arst_idx", idx1, 0);
    chk("arst_done", dn1, 0);
    chk("arst_ready", rdy1, 1);
    q1.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    accept_sym(0, 4'd5, 32'h3522ED9C, ea);
    wait_idle(0);

    // Next symbol offered only in the final chip cycle: one idle cycle
    accept_sym(0, 4'd0, 32'hD9C3522E, ea);
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      hit = dn1;
    end
    chk("reach_last_chip", 32'(hit), 32'd1);
    #1;
    accept_sym(0, 4'd7, 32'h9C3522ED, ea);
    @(negedge clk);
    chk("late_gap_idle", v1, 0);
    @(negedge clk);
    chk("late_resume", v1, 1);
    wait_idle(0);

    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
